comp_fun_seq: RTL and testbench

//   Parametrised, clocked successor to the 3-bit functionality comparator.
//   - Holds a reference code of WIDTH bits, loaded from the interface.
//   - Compares a stream of valid-qualified sample codes against that reference.
//   - Asserts a stable MATCH only after HOLD consecutive equal samples (debounced equality).
//   - Counts mismatching samples for diagnostics.
//   - Sits between the interface selection logic and the functionality-dispatch control.
//

---
 rtl/comp_fun_seq.sv | 143 ++++++++++++++
 tb/tb_comp_fun_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/comp_fun_seq.sv
// -----------------------------------------------------------------------------
// comp_fun_seq
//   Clocked, debounced code comparator. It holds a WIDTH-bit reference code and
//   compares a valid-qualified stream of sample codes against it. MATCH is only
//   reported after HOLD consecutive equal valid samples. Unequal valid samples
//   are counted in a saturating diagnostic counter.
//
// Parameters
//   WIDTH  bit width of reference and sample codes (>=1)
//   HOLD   consecutive equal valid samples needed to assert match (>=1)
//   CNT_W  width of the saturating mismatch counter (>=1)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous reset, active-low
//   clear     in   synchronous clear to IDLE, zeroes counters (reference kept)
//   load      in   capture ref_in as the new reference and go ARMED
//   ref_in    in   reference code, sampled when load=1
//   valid     in   sample qualifier
//   sample    in   code compared against the stored reference
//   equal     out  registered result of the last valid compare
//   match     out  registered, high while debounced equality holds
//   state     out  FSM state: 00 IDLE, 01 ARMED, 10 MATCH
//   miss_cnt  out  saturating count of unequal valid samples
// -----------------------------------------------------------------------------
module comp_fun_seq #(
  parameter int WIDTH = 3,
  parameter int HOLD  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] ref_in,
  input  logic             valid,
  input  logic [WIDTH-1:0] sample,
  output logic             equal,
  output logic             match,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int              RC_W   = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [RC_W-1:0] HOLD_V = RC_W'(HOLD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_MATCH = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  state_t           st_q;
  logic [WIDTH-1:0] ref_reg;
  logic [RC_W-1:0]  run_cnt;
  logic             eq;
  logic [RC_W-1:0]  run_nxt;

  // Run length advance, held at HOLD so a long MATCH cannot wrap the counter.
  function automatic logic [RC_W-1:0] sat_run(input logic [RC_W-1:0] r);
    return (r >= HOLD_V) ? HOLD_V : r + RC_W'(1);
  endfunction

  // Mismatch counter advance, sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_miss(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign eq      = (sample == ref_reg);
  assign run_nxt = sat_run(run_cnt);
  assign state   = st_q;

  // Single registered FSM; clear outranks load, load outranks the sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= S_IDLE;
      ref_reg  <= '0;
      run_cnt  <= '0;
      equal    <= 1'b0;
      match    <= 1'b0;
      miss_cnt <= '0;
    end else if (clear) begin
      st_q     <= S_IDLE;
      run_cnt  <= '0;
      equal    <= 1'b0;
      match    <= 1'b0;
      miss_cnt <= '0;
    end else if (load) begin
      // The sample presented alongside load is dropped on purpose.
      ref_reg <= ref_in;
      run_cnt <= '0;
      equal   <= 1'b0;
      match   <= 1'b0;
      st_q    <= S_ARMED;
    end else begin
      case (st_q)
        S_IDLE: begin
          // Samples are ignored until a reference has been loaded.
        end
        S_ARMED: begin
          if (valid) begin
            if (eq) begin
              equal   <= 1'b1;
              run_cnt <= run_nxt;
              if (run_nxt == HOLD_V) begin
                match <= 1'b1;
                st_q  <= S_MATCH;
              end
            end else begin
              equal    <= 1'b0;
              run_cnt  <= '0;
              miss_cnt <= sat_miss(miss_cnt);
            end
          end
        end
        S_MATCH: begin
          if (valid) begin
            if (eq) begin
              equal   <= 1'b1;
              match   <= 1'b1;
              run_cnt <= run_nxt;
            end else begin
              equal    <= 1'b0;
              match    <= 1'b0;
              run_cnt  <= '0;
              miss_cnt <= sat_miss(miss_cnt);
              st_q     <= S_ARMED;
            end
          end
        end
        default: begin
          // Encoding 11 is never produced; recover to a clean IDLE.
          st_q    <= S_IDLE;
          run_cnt <= '0;
          equal   <= 1'b0;
          match   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp_fun_seq.sv
// -----------------------------------------------------------------------------
// tb_comp_fun_seq
//   Drives two comparator instances (HOLD=4/CNT_W=8 and HOLD=1/CNT_W=2) with
//   the same stimulus. A reference model tracks "loaded or not", the reference
//   code, the trailing run of equal samples and the total miss count; expected
//   outputs for each instance are derived from that and queued per clock edge.
//   A monitor pops and compares one entry after every edge.
// -----------------------------------------------------------------------------
module tb_comp_fun_seq;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] ref_in = '0;
  logic [W-1:0] sample = '0;

  logic         eq_a, m_a;
  logic [1:0]   st_a;
  logic [7:0]   mc_a;
  logic         eq_b, m_b;
  logic [1:0]   st_b;
  logic [1:0]   mc_b;

  comp_fun_seq #(.WIDTH(W), .HOLD(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .ref_in(ref_in),
    .valid(valid), .sample(sample), .equal(eq_a), .match(m_a),
    .state(st_a), .miss_cnt(mc_a)
  );

  comp_fun_seq #(.WIDTH(W), .HOLD(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .ref_in(ref_in),
    .valid(valid), .sample(sample), .equal(eq_b), .match(m_b),
    .state(st_b), .miss_cnt(mc_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           armed;
    logic [W-1:0] rf;
    int           streak;
    int           misses;
    bit           last_eq;
  } mdl_t;

  typedef struct {
    logic [31:0] eq;
    logic [31:0] m;
    logic [31:0] st;
    logic [31:0] mc;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } pair_t;

  pair_t q[$];
  mdl_t  mdl = '{armed: 1'b0, rf: '0, streak: 0, misses: 0, last_eq: 1'b0};
  int    n_chk  = 0;
  int    n_fail = 0;

  function automatic mdl_t step(mdl_t s, bit rn, bit cl, bit ld,
                                logic [W-1:0] ri, bit v, logic [W-1:0] smp);
    mdl_t n = s;
    if (!rn) begin
      n = '{armed: 1'b0, rf: '0, streak: 0, misses: 0, last_eq: 1'b0};
    end else if (cl) begin
      n.armed = 1'b0; n.streak = 0; n.misses = 0; n.last_eq = 1'b0;
    end else if (ld) begin
      n.armed = 1'b1; n.rf = ri; n.streak = 0; n.last_eq = 1'b0;
    end else if (v && s.armed) begin
      if (smp == s.rf) begin
        n.streak = s.streak + 1; n.last_eq = 1'b1;
      end else begin
        n.streak = 0; n.misses = s.misses + 1; n.last_eq = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic exp_t expect_of(mdl_t s, int hold, int maxc);
    exp_t e;
    bit   mt = s.armed && (s.streak >= hold);
    e.eq = 32'(s.last_eq);
    e.m  = 32'(mt);
    e.st = !s.armed ? 32'd0 : (mt ? 32'd2 : 32'd1);
    e.mc = 32'((s.misses > maxc) ? maxc : s.misses);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, update the model at the
  // rising edge and queue what both instances must show afterwards.
  task automatic cyc(input bit rn, input bit cl, input bit ld,
                     input logic [W-1:0] ri, input bit v, input logic [W-1:0] smp);
    @(negedge clk);
    rst_n = rn; clear = cl; load = ld; ref_in = ri; valid = v; sample = smp;
    if (!rn) begin
      #1;
      chk("rst_eq_a", 32'(eq_a), 32'd0);
      chk("rst_m_a",  32'(m_a),  32'd0);
      chk("rst_st_a", 32'(st_a), 32'd0);
      chk("rst_mc_a", 32'(mc_a), 32'd0);
      chk("rst_eq_b", 32'(eq_b), 32'd0);
      chk("rst_m_b",  32'(m_b),  32'd0);
      chk("rst_st_b", 32'(st_b), 32'd0);
      chk("rst_mc_b", 32'(mc_b), 32'd0);
    end
    @(posedge clk);
    mdl = step(mdl, rn, cl, ld, ri, v, smp);
    q.push_back('{a: expect_of(mdl, 4, 255), b: expect_of(mdl, 1, 3)});
  endtask

  task automatic smp_v(input logic [W-1:0] s);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, s);
  endtask

  task automatic gap();
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic ld(input logic [W-1:0] r);
    cyc(1'b1, 1'b0, 1'b1, r, 1'b0, '0);
  endtask

  task automatic clr();
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
  endtask

  // Monitor: every output update is compared against the queued expectation.
  initial begin
    forever begin
      pair_t p;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        p = q.pop_front();
        chk("equal_a", 32'(eq_a), p.a.eq);
        chk("match_a", 32'(m_a),  p.a.m);
        chk("state_a", 32'(st_a), p.a.st);
        chk("miss_a",  32'(mc_a), p.a.mc);
        chk("equal_b", 32'(eq_b), p.b.eq);
        chk("match_b", 32'(m_b),  p.b.m);
        chk("state_b", 32'(st_b), p.b.st);
        chk("miss_b",  32'(mc_b), p.b.mc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] r;
    logic [W-1:0] s;
    // Reset, then valid samples while IDLE are ignored.
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 5; i++) smp_v(3'b101);

    // Debounce with gaps between equal samples.
    ld(3'b110);
    for (int i = 0; i < 4; i++) begin
      smp_v(3'b110);
      gap();
    end

    // Broken run restarts the count.
    clr();
    ld(3'b110);
    smp_v(3'b110); smp_v(3'b110); smp_v(3'b111);
    for (int i = 0; i < 4; i++) smp_v(3'b110);

    // Drop out of MATCH.
    smp_v(3'b010);

    // Priority: clear over load and valid, then load discards its own sample.
    cyc(1'b1, 1'b1, 1'b1, 3'b011, 1'b1, 3'b011);
    cyc(1'b1, 1'b0, 1'b1, 3'b110, 1'b1, 3'b110);
    smp_v(3'b110);

    // Saturation on the narrow counter, single-sample match, reset in MATCH.
    clr();
    ld(3'b001);
    for (int i = 0; i < 5; i++) smp_v(3'b000);
    smp_v(3'b001);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 3'b001);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);

    // Saturation on the wide counter.
    ld(3'b111);
    for (int i = 0; i < 260; i++) smp_v(3'($urandom_range(0, 6)));
    smp_v(3'b111);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int  roll = $urandom_range(0, 999);
      bit  rn   = (roll >= 8);
      bit  cl   = ($urandom_range(0, 99) < 3);
      bit  lo   = ($urandom_range(0, 99) < 6);
      bit  v    = ($urandom_range(0, 99) < 65);
      r = 3'($urandom);
      s = ($urandom_range(0, 99) < 70) ? mdl.rf : 3'($urandom);
      cyc(rn, cl, lo, r, v, s);
    end

    gap();
    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
